// File: rtl/gpio_frame_controller.sv
// gpio_frame_controller
//   Command decoder between the soft-core GPIO pair (gpi0/gpo0) and the
//   convolution engine. It decodes strobed commands and streams packed pixels
//   into frame memory with an auto-incrementing address. It also starts the
//   convolution and reads the results back one word at a time. A status word,
//   a programmable frame length and sticky error flags are provided.
//
// Ports
//   clock / reset        system clock, synchronous active-high reset
//   i_cmd_from_micro     gpi0: [MSB]=strobe, [MSB-1 -: NB_CMD]=cmd, [NB_PL-1:0]=payload
//   o_data_to_micro      gpo0 readback (status word or result word)
//   o_kernel_sel         active kernel index
//   o_wr_en/_addr/_data  frame-memory write port (one-cycle pulse)
//   o_start_conv         one-cycle convolution start pulse
//   i_conv_done          one-cycle done pulse from the engine
//   i_out_words          result word count, sampled on i_conv_done
//   o_rd_en/_addr        result-memory read port (RAM latency 1)
//   i_rd_data            result word, valid the cycle after o_rd_en
module gpio_frame_controller #(
  parameter  int NB_INST    = 32,
  parameter  int NB_CMD     = 7,
  parameter  int NB_PIX     = 8,
  parameter  int PIX_PER_WR = 3,
  parameter  int NB_ADDR    = 12,
  parameter  int N_KERNEL   = 4,
  parameter  int MAX_WORDS  = 1024,
  localparam int NB_KSEL    = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1,
  localparam int NB_PL      = NB_PIX * PIX_PER_WR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NB_INST-1:0] i_cmd_from_micro,
  output logic [NB_INST-1:0] o_data_to_micro,
  output logic [NB_KSEL-1:0] o_kernel_sel,
  output logic               o_wr_en,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic [NB_PL-1:0]   o_wr_data,
  output logic               o_start_conv,
  input  logic               i_conv_done,
  input  logic [NB_ADDR:0]   i_out_words,
  output logic               o_rd_en,
  output logic [NB_ADDR-1:0] o_rd_addr,
  input  logic [NB_INST-1:0] i_rd_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOADING   = 2'd1,
    CONV_WAIT = 2'd2,
    READOUT   = 2'd3
  } state_t;

  typedef enum logic [NB_CMD-1:0] {
    CMD_KERNEL_SEL = NB_CMD'(0),
    CMD_LOAD       = NB_CMD'(1),
    CMD_END_FRAME  = NB_CMD'(2),
    CMD_GET_STATUS = NB_CMD'(3),
    CMD_GET_FRAME  = NB_CMD'(4),
    CMD_CLEAR      = NB_CMD'(5),
    CMD_SET_LEN    = NB_CMD'(6)
  } cmd_t;

  localparam logic [NB_ADDR:0] PTR_ONE   = (NB_ADDR+1)'(1);
  localparam logic [NB_ADDR:0] LEN_RESET = (NB_ADDR+1)'(MAX_WORDS);
  localparam logic [NB_PL-1:0] KSEL_LIM  = NB_PL'(N_KERNEL);

  state_t             state_q;
  logic               strobe_q;
  logic [NB_ADDR:0]   wr_ptr_q;
  logic [NB_ADDR:0]   rd_ptr_q;
  logic [NB_ADDR:0]   rd_len_q;
  logic [NB_ADDR:0]   frame_len_q;
  logic [NB_KSEL-1:0] kernel_sel_q;
  logic               frame_ready_q;
  logic               err_ovf_q;
  logic               err_cmd_q;
  logic               wr_en_q;
  logic [NB_ADDR-1:0] wr_addr_q;
  logic [NB_PL-1:0]   wr_data_q;
  logic               start_conv_q;
  logic               rd_en_q;
  logic [NB_ADDR-1:0] rd_addr_q;
  logic               rd_valid_q;
  logic [NB_INST-1:0] gpo_q;

  logic               strobe;
  logic               exec;
  logic [NB_CMD-1:0]  cmd;
  logic [NB_PL-1:0]   payload;
  logic [NB_ADDR:0]   rd_ptr_inc;
  logic [NB_INST-1:0] status;

  assign strobe     = i_cmd_from_micro[NB_INST-1];
  assign cmd        = i_cmd_from_micro[NB_INST-2 -: NB_CMD];
  assign payload    = i_cmd_from_micro[NB_PL-1:0];
  assign exec       = strobe & ~strobe_q;
  assign rd_ptr_inc = rd_ptr_q + PTR_ONE;

  always_comb begin
    status                = '0;
    status[16 +: NB_ADDR] = wr_ptr_q[NB_ADDR-1:0];
    status[8 +: NB_KSEL]  = kernel_sel_q;
    status[4]             = err_ovf_q;
    status[3]             = err_cmd_q;
    status[2:1]           = state_q;
    status[0]             = frame_ready_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      strobe_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_len_q      <= '0;
      frame_len_q   <= LEN_RESET;
      kernel_sel_q  <= '0;
      frame_ready_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_cmd_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      start_conv_q  <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      rd_valid_q    <= 1'b0;
      gpo_q         <= '0;
    end else begin
      strobe_q     <= strobe;
      wr_en_q      <= 1'b0;
      start_conv_q <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_valid_q   <= rd_en_q;

      // Hold the result word once the RAM has produced it.
      if (rd_valid_q) gpo_q <= i_rd_data;

      if (i_conv_done && state_q == CONV_WAIT) begin
        state_q       <= READOUT;
        frame_ready_q <= 1'b1;
        rd_ptr_q      <= '0;
        rd_len_q      <= i_out_words;
      end

      // Commands are evaluated after conv_done so that CLEAR in the same
      // cycle drops the pending completion.
      if (exec) begin
        case (cmd)
          CMD_KERNEL_SEL: begin
            if ((state_q == IDLE || state_q == LOADING) && payload < KSEL_LIM)
              kernel_sel_q <= payload[NB_KSEL-1:0];
            else
              err_cmd_q <= 1'b1;
          end
          CMD_LOAD: begin
            if (state_q == IDLE || state_q == LOADING) begin
              state_q <= LOADING;
              if (wr_ptr_q == frame_len_q) begin
                err_ovf_q <= 1'b1;
              end else begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= wr_ptr_q[NB_ADDR-1:0];
                wr_data_q <= payload;
                wr_ptr_q  <= wr_ptr_q + PTR_ONE;
              end
            end else begin
              err_cmd_q <= 1'b1;
            end
          end
          CMD_END_FRAME: begin
            if (state_q == LOADING && wr_ptr_q != '0) begin
              start_conv_q <= 1'b1;
              state_q      <= CONV_WAIT;
            end else begin
              err_cmd_q <= 1'b1;
            end
          end
          CMD_GET_STATUS: gpo_q <= status;
          CMD_GET_FRAME: begin
            if (state_q == READOUT) begin
              if (rd_ptr_q < rd_len_q) begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= rd_ptr_q[NB_ADDR-1:0];
                rd_ptr_q  <= rd_ptr_inc;
              end
              // Last word issued (or nothing left): frame is finished.
              if (rd_ptr_q >= rd_len_q || rd_ptr_inc == rd_len_q) begin
                state_q       <= IDLE;
                frame_ready_q <= 1'b0;
                wr_ptr_q      <= '0;
              end
            end else begin
              err_cmd_q <= 1'b1;
            end
          end
          CMD_CLEAR: begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_len_q      <= '0;
            frame_ready_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_cmd_q     <= 1'b0;
          end
          CMD_SET_LEN: begin
            if (state_q == IDLE) begin
              if (payload[NB_ADDR:0] == '0) frame_len_q <= PTR_ONE;
              else                          frame_len_q <= payload[NB_ADDR:0];
            end else begin
              err_cmd_q <= 1'b1;
            end
          end
          default: err_cmd_q <= 1'b1;
        endcase
      end
    end
  end

  // The RAM word is forwarded straight through during its valid cycle so it
  // appears on gpo0 two cycles after GET_FRAME; gpo_q holds it afterwards.
  assign o_data_to_micro = rd_valid_q ? i_rd_data : gpo_q;
  assign o_kernel_sel    = kernel_sel_q;
  assign o_wr_en         = wr_en_q;
  assign o_wr_addr       = wr_addr_q;
  assign o_wr_data       = wr_data_q;
  assign o_start_conv    = start_conv_q;
  assign o_rd_en         = rd_en_q;
  assign o_rd_addr       = rd_addr_q;

endmodule

// File: tb/tb_gpio_frame_controller.sv
module tb_gpio_frame_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_w;
  logic [31:0] data_o;
  logic [1:0]  ksel;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [23:0] wr_data;
  logic        start_conv;
  logic        conv_done;
  logic [12:0] out_words;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;

  logic [31:0] ram [0:3];
  int npass = 0;
  int ntotal = 0;
  int wr_count;

  always #5 clk = ~clk;

  gpio_frame_controller #(
    .NB_INST(32), .NB_CMD(7), .NB_PIX(8), .PIX_PER_WR(3),
    .NB_ADDR(12), .N_KERNEL(4), .MAX_WORDS(1024)
  ) dut (
    .clock(clk),
    .reset(rst),
    .i_cmd_from_micro(cmd_w),
    .o_data_to_micro(data_o),
    .o_kernel_sel(ksel),
    .o_wr_en(wr_en),
    .o_wr_addr(wr_addr),
    .o_wr_data(wr_data),
    .o_start_conv(start_conv),
    .i_conv_done(conv_done),
    .i_out_words(out_words),
    .o_rd_en(rd_en),
    .o_rd_addr(rd_addr),
    .i_rd_data(rd_data)
  );

  // Result RAM with one cycle of read latency.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr[1:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Raise strobe for one cycle; returns at the negedge inside cycle t+1.
  task automatic issue(input logic [6:0] c, input logic [23:0] p);
    @(negedge clk);
    cmd_w = {1'b1, c, p};
    @(negedge clk);
    cmd_w = '0;
  endtask

  task automatic status_is(input string tag, input logic [31:0] exp);
    issue(7'd3, 24'd0);
    chk(tag, data_o, exp);
  endtask

  task automatic done_pulse(input logic [12:0] words);
    @(negedge clk);
    conv_done = 1'b1;
    out_words = words;
    @(negedge clk);
    conv_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_w = '0; conv_done = 1'b0; out_words = '0; rd_data = '0;
    ram[0] = 32'hDEADBEEF; ram[1] = 32'h12345678; ram[2] = '0; ram[3] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset state, kernel select, out-of-range kernel
    chk("rst_gpo", data_o, 32'h0);
    chk("rst_ksel", {30'd0, ksel}, 32'd0);
    chk("rst_pulses", {29'd0, wr_en, rd_en, start_conv}, 32'd0);
    status_is("status_reset", 32'h0000_0000);
    issue(7'd0, 24'd2);
    chk("ksel_2", {30'd0, ksel}, 32'd2);
    issue(7'd0, 24'd5);
    chk("ksel_5_unchanged", {30'd0, ksel}, 32'd2);
    status_is("status_err_cmd", 32'h0000_0208);

    // 2: SET_LEN 3 and four loads, fourth overflows
    issue(7'd6, 24'd3);
    issue(7'd1, 24'h010203);
    chk("ld0_en", {31'd0, wr_en}, 32'd1);
    chk("ld0_addr", {20'd0, wr_addr}, 32'd0);
    chk("ld0_data", {8'd0, wr_data}, 32'h010203);
    @(negedge clk);
    chk("ld0_pulse_end", {31'd0, wr_en}, 32'd0);
    issue(7'd1, 24'h040506);
    chk("ld1_addr", {19'd0, wr_en, wr_addr}, 32'h1001);
    chk("ld1_data", {8'd0, wr_data}, 32'h040506);
    issue(7'd1, 24'h070809);
    chk("ld2_addr", {19'd0, wr_en, wr_addr}, 32'h1002);
    chk("ld2_data", {8'd0, wr_data}, 32'h070809);
    issue(7'd1, 24'h0A0B0C);
    chk("ld3_dropped", {31'd0, wr_en}, 32'd0);
    status_is("status_ovf", 32'h0003_021A);

    // 3: END_FRAME and conv_done
    issue(7'd2, 24'd0);
    chk("start_pulse", {31'd0, start_conv}, 32'd1);
    @(negedge clk);
    chk("start_pulse_end", {31'd0, start_conv}, 32'd0);
    status_is("status_conv_wait", 32'h0003_021C);
    done_pulse(13'd2);
    status_is("status_readout", 32'h0003_021F);

    // 4: two result words read back
    issue(7'd4, 24'd0);
    chk("rd0_en_addr", {19'd0, rd_en, rd_addr}, 32'h1000);
    @(negedge clk);
    chk("rd0_data", data_o, 32'hDEADBEEF);
    chk("rd0_pulse_end", {31'd0, rd_en}, 32'd0);
    @(negedge clk);
    chk("rd0_data_held", data_o, 32'hDEADBEEF);
    issue(7'd4, 24'd0);
    chk("rd1_en_addr", {19'd0, rd_en, rd_addr}, 32'h1001);
    @(negedge clk);
    chk("rd1_data", data_o, 32'h12345678);
    status_is("status_after_readout", 32'h0000_0218);

    // 5: strobe held high gives one execution; GET_FRAME outside READOUT
    issue(7'd5, 24'd0);
    status_is("status_clear", 32'h0000_0200);
    wr_count = 0;
    @(negedge clk);
    cmd_w = {1'b1, 7'd1, 24'h111111};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en) wr_count++;
    end
    cmd_w = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (wr_en) wr_count++;
    end
    chk("held_strobe_one_write", wr_count, 32'd1);
    status_is("status_held", 32'h0001_0202);
    issue(7'd5, 24'd0);
    issue(7'd4, 24'd0);
    chk("getframe_idle_no_rd", {31'd0, rd_en}, 32'd0);
    chk("getframe_idle_gpo", data_o, 32'h0001_0202);
    status_is("status_getframe_idle", 32'h0000_0208);

    // 6: CLEAR in CONV_WAIT drops the later done; reset during LOADING
    issue(7'd5, 24'd0);
    issue(7'd1, 24'h555555);
    issue(7'd2, 24'd0);
    chk("start_pulse2", {31'd0, start_conv}, 32'd1);
    status_is("status_conv_wait2", 32'h0001_0204);
    issue(7'd5, 24'd0);
    done_pulse(13'd2);
    status_is("status_done_dropped", 32'h0000_0200);
    issue(7'd1, 24'hA5A5A5);
    issue(7'd1, 24'h5A5A5A);
    chk("pre_rst_addr", {20'd0, wr_addr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ksel2", {30'd0, ksel}, 32'd0);
    chk("rst_gpo2", data_o, 32'd0);
    chk("rst_wr_port", {8'd0, wr_data}, 32'd0);
    chk("rst_addrs", {8'd0, wr_addr, rd_addr}, 32'd0);
    chk("rst_pulses2", {29'd0, wr_en, rd_en, start_conv}, 32'd0);
    rst = 1'b0;
    status_is("status_reset2", 32'h0000_0000);

    // Boundaries: SET_LEN 0 acts as 1; unknown command
    issue(7'd6, 24'd0);
    issue(7'd1, 24'hABCDEF);
    chk("len0_first_write", {31'd0, wr_en}, 32'd1);
    issue(7'd1, 24'h123456);
    chk("len0_second_dropped", {31'd0, wr_en}, 32'd0);
    status_is("status_len0", 32'h0001_0012);
    issue(7'd7, 24'd0);
    status_is("status_bad_cmd", 32'h0001_001A);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
